// File: rtl/t2mi_timestamp_tx.sv
// T2-MI timestamp packet (type 0x20) transmitter.
// Latches time fields on start and streams 16 bytes with backpressure.
module t2mi_timestamp_tx #(
    parameter logic [7:0]  SYNC_BYTE   = 8'h47,
    parameter logic [7:0]  PACKET_TYPE = 8'h20,
    parameter logic [15:0] PAYLOAD_LEN = 16'h000C,
    parameter int          GAP_CYCLES  = 1
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        start,
    input  logic [39:0] seconds,
    input  logic [31:0] subseconds,
    input  logic [12:0] utc_offset,
    input  logic [3:0]  bandwidth,
    input  logic        out_ready,
    output logic        t2mi_valid,
    output logic [7:0]  t2mi_data,
    output logic        t2mi_sync,
    output logic        busy,
    output logic        done,
    output logic        start_dropped,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [39:0] sec_q;
    logic [31:0] sub_q;
    logic [12:0] utc_q;
    logic [3:0]  bw_q;

    logic        latch_en;
    logic        done_d;
    logic        drop_d;
    logic [15:0] cnt_d;
    logic [7:0]  byte_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        latch_en = 1'b0;
        done_d   = 1'b0;
        cnt_d    = pkt_count;
        drop_d   = start && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    latch_en = 1'b1;
                    state_d  = SYNC;
                end
            end
            SYNC: begin
                state_d = DATA;
                idx_d   = 4'd0;
            end
            DATA: begin
                if (t2mi_valid && out_ready) begin
                    if (idx_q == 4'd15) begin
                        done_d  = 1'b1;
                        cnt_d   = pkt_count + 16'd1;
                        idx_d   = 4'd0;
                        gap_d   = 4'd0;
                        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else gap_d = gap_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte for the next cycle; byte 0 is constant so the fields latched
    // on the IDLE->SYNC edge are always settled before they are needed.
    always_comb begin
        byte_d = 8'h00;
        case (idx_d)
            4'd0:    byte_d = SYNC_BYTE;
            4'd1:    byte_d = PACKET_TYPE;
            4'd2:    byte_d = PAYLOAD_LEN[15:8];
            4'd3:    byte_d = PAYLOAD_LEN[7:0];
            4'd4:    byte_d = {4'h0, bw_q};
            4'd5:    byte_d = {3'b000, utc_q[12:8]};
            4'd6:    byte_d = utc_q[7:0];
            4'd7:    byte_d = sec_q[39:32];
            4'd8:    byte_d = sec_q[31:24];
            4'd9:    byte_d = sec_q[23:16];
            4'd10:   byte_d = sec_q[15:8];
            4'd11:   byte_d = sec_q[7:0];
            4'd12:   byte_d = sub_q[31:24];
            4'd13:   byte_d = sub_q[23:16];
            4'd14:   byte_d = sub_q[15:8];
            default: byte_d = sub_q[7:0];
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            sec_q <= '0;
            sub_q <= '0;
            utc_q <= '0;
            bw_q  <= '0;
        end else if (latch_en) begin
            sec_q <= seconds;
            sub_q <= subseconds;
            utc_q <= utc_offset;
            bw_q  <= bandwidth;
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            t2mi_valid    <= 1'b0;
            t2mi_data     <= 8'h00;
            t2mi_sync     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            start_dropped <= 1'b0;
            pkt_count     <= 16'd0;
        end else begin
            t2mi_valid    <= (state_d == DATA);
            t2mi_data     <= (state_d == DATA) ? byte_d : 8'h00;
            t2mi_sync     <= (state_d == SYNC);
            busy          <= (state_d != IDLE);
            done          <= done_d;
            start_dropped <= drop_d;
            pkt_count     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_t2mi_timestamp_tx.sv
// Directed bench for t2mi_timestamp_tx.
// Hand-computed byte sequences, backpressure, busy start, reset, wrap.
module tb_t2mi_timestamp_tx;

    logic        clk_100mhz = 1'b0;
    logic        rst;
    logic        start;
    logic [39:0] seconds;
    logic [31:0] subseconds;
    logic [12:0] utc_offset;
    logic [3:0]  bandwidth;
    logic        out_ready;
    logic        t2mi_valid;
    logic [7:0]  t2mi_data;
    logic        t2mi_sync;
    logic        busy;
    logic        done;
    logic        start_dropped;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] basic_b [16] = '{
        8'h47, 8'h20, 8'h00, 8'h0C, 8'h08, 8'h00, 8'h00, 8'h00,
        8'h2F, 8'h05, 8'hF0, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
    logic [7:0] max_b [16] = '{
        8'h47, 8'h20, 8'h00, 8'h0C, 8'h0F, 8'h1F, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_b [16];

    t2mi_timestamp_tx dut (
        .clk_100mhz    (clk_100mhz),
        .rst           (rst),
        .start         (start),
        .seconds       (seconds),
        .subseconds    (subseconds),
        .utc_offset    (utc_offset),
        .bandwidth     (bandwidth),
        .out_ready     (out_ready),
        .t2mi_valid    (t2mi_valid),
        .t2mi_data     (t2mi_data),
        .t2mi_sync     (t2mi_sync),
        .busy          (busy),
        .done          (done),
        .start_dropped (start_dropped),
        .pkt_count     (pkt_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic set_basic();
        seconds    = 40'd788918400;
        subseconds = 32'h8000_0000;
        utc_offset = 13'd0;
        bandwidth  = 4'd8;
    endtask

    task automatic set_max();
        seconds    = 40'hFF_FFFF_FFFF;
        subseconds = 32'hFFFF_FFFF;
        utc_offset = 13'h1FFF;
        bandwidth  = 4'hF;
    endtask

    // Call at a negedge with start already high: moves to N+1.
    task automatic expect_sync();
        @(negedge clk_100mhz);
        start = 1'b0;
        check("sync", t2mi_sync, 1);
        check("sync_valid", t2mi_valid, 0);
        check("sync_busy", busy, 1);
    endtask

    // Receives one packet from N+2 on; optional stall, busy poke, reset.
    task automatic run_pkt(input int stall_b, input int stall_n,
                           input int poke_b, input int rst_b,
                           input logic [15:0] exp_cnt);
        int k = 0;
        int n = 0;
        int held = 0;
        bit poked = 0;
        bit pend = 0;
        while (k < 16 && n < 60) begin
            @(negedge clk_100mhz);
            n++;
            start = 1'b0;
            if (pend) begin
                check("dropped", start_dropped, 1);
                pend = 0;
            end
            check($sformatf("valid%0d", k), t2mi_valid, 1);
            check($sformatf("byte%0d", k), t2mi_data, exp_b[k]);
            if (k == rst_b) begin
                rst = 1'b1;
                #1;
                check("rst_valid", t2mi_valid, 0);
                check("rst_sync", t2mi_sync, 0);
                check("rst_busy", busy, 0);
                check("rst_cnt", pkt_count, 0);
                return;
            end
            if (k == poke_b && !poked) begin
                start = 1'b1;
                set_max();
                poked = 1;
                pend  = 1;
            end
            if (k == stall_b && held < stall_n) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = 1'b1;
                k++;
            end
        end
        check("ncycles", n, 16 + stall_n);
        @(negedge clk_100mhz);
        out_ready = 1'b1;
        check("done", done, 1);
        check("done_valid", t2mi_valid, 0);
        check("done_busy", busy, 1);
        check("pkt_count", pkt_count, exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        set_basic();
        repeat (3) @(negedge clk_100mhz);
        check("rst0_valid", t2mi_valid, 0);
        check("rst0_busy", busy, 0);
        check("rst0_cnt", pkt_count, 0);
        check("rst0_data", t2mi_data, 0);
        rst = 1'b0;
        @(negedge clk_100mhz);

        // Basic packet, then start in done cycle (dropped) and at N+19
        exp_b = basic_b;
        start = 1'b1;
        expect_sync();
        run_pkt(-1, 0, -1, -1, 16'd1);
        start = 1'b1;
        @(negedge clk_100mhz);
        check("gap_drop", start_dropped, 1);
        check("idle_busy", busy, 0);
        check("idle_valid", t2mi_valid, 0);
        check("idle_done", done, 0);
        set_max();
        exp_b = max_b;
        start = 1'b1;
        expect_sync();
        run_pkt(-1, 0, -1, -1, 16'd2);
        @(negedge clk_100mhz);
        check("gap_end_busy", busy, 0);

        // Backpressure on byte 7
        set_basic();
        exp_b = basic_b;
        start = 1'b1;
        expect_sync();
        run_pkt(7, 3, -1, -1, 16'd3);
        @(negedge clk_100mhz);

        // Start while busy with different fields
        set_basic();
        start = 1'b1;
        expect_sync();
        run_pkt(-1, 0, 5, -1, 16'd4);
        @(negedge clk_100mhz);
        check("poke_once", pkt_count, 4);

        // Reset while byte 9 is presented
        set_basic();
        start = 1'b1;
        expect_sync();
        run_pkt(-1, 0, -1, 9, 16'd0);
        @(negedge clk_100mhz);
        rst = 1'b0;
        check("post_rst_done", done, 0);
        @(negedge clk_100mhz);
        start = 1'b1;
        expect_sync();
        run_pkt(-1, 0, -1, -1, 16'd1);
        @(negedge clk_100mhz);

        // Counter wrap
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        @(negedge clk_100mhz);
        check("preload", pkt_count, 16'hFFFF);
        start = 1'b1;
        expect_sync();
        run_pkt(-1, 0, -1, -1, 16'd0);
        @(negedge clk_100mhz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
